// File: rtl/vtg_pkg.sv
// Shared constants for the raster timing generator: coordinate width and
// the standard 720p60 / 1080p60 timing sets.
package vtg_pkg;

  localparam int COORD_W         = 12;
  localparam int COORD_MAX_TOTAL = 1 << COORD_W;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } vtg_timing_t;

  localparam vtg_timing_t VTG_720P60 = '{
    h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
    v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20
  };

  localparam vtg_timing_t VTG_1080P60 = '{
    h_active: 1920, h_fp: 88, h_sync: 44, h_bp: 148,
    v_active: 1080, v_fp: 4,  v_sync: 5,  v_bp: 36
  };

  function automatic int vtg_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vtg_wrap_counter.sv
// Modulo-N up-counter. o_wrap flags the increment that returns the count to 0,
// so it can be chained as the increment of the next counter.
module vtg_wrap_counter
  import vtg_pkg::*;
#(
  parameter int N = 2,
  parameter int W = COORD_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;
  logic         at_last;

  assign at_last = (count_reg == LAST);
  assign o_wrap  = i_inc && at_last;
  assign o_count = count_reg;

  always_comb begin
    count_next = count_reg;
    if (i_inc) begin
      count_next = at_last ? '0 : count_reg + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: h/v counters, registered coordinates, DE and syncs.
// Define VTG_ANIMATE_EN to build the per-frame o_animate pulse and o_frame counter.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int H_ACTIVE = VTG_720P60.h_active,
  parameter int H_FP     = VTG_720P60.h_fp,
  parameter int H_SYNC   = VTG_720P60.h_sync,
  parameter int H_BP     = VTG_720P60.h_bp,
  parameter int V_ACTIVE = VTG_720P60.v_active,
  parameter int V_FP     = VTG_720P60.v_fp,
  parameter int V_SYNC   = VTG_720P60.v_sync,
  parameter int V_BP     = VTG_720P60.v_bp,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_de,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_animate,
  output logic [15:0]        o_frame
);

  localparam int H_TOTAL = vtg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vtg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > COORD_MAX_TOTAL || V_TOTAL > COORD_MAX_TOTAL) begin : g_total_check
    $error("video_timing_gen: H_TOTAL or V_TOTAL exceeds the coordinate range");
  end

  // Per-axis window bounds, index 0 = horizontal, 1 = vertical.
  localparam int ACTIVE_END [2] = '{H_ACTIVE, V_ACTIVE};
  localparam int SYNC_START [2] = '{H_ACTIVE + H_FP, V_ACTIVE + V_FP};
  localparam int SYNC_END   [2] = '{H_ACTIVE + H_FP + H_SYNC, V_ACTIVE + V_FP + V_SYNC};

  logic [COORD_W-1:0] h_count;
  logic [COORD_W-1:0] v_count;
  logic               h_wrap;
  logic               v_wrap_unused;

  vtg_wrap_counter #(.N(H_TOTAL), .W(COORD_W)) u_h_counter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (i_en),
    .o_count (h_count),
    .o_wrap  (h_wrap)
  );

  vtg_wrap_counter #(.N(V_TOTAL), .W(COORD_W)) u_v_counter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (h_wrap),
    .o_count (v_count),
    .o_wrap  (v_wrap_unused)
  );

  logic [COORD_W-1:0] axis_count [2];
  logic [1:0]         axis_active;
  logic [1:0]         axis_sync;

  assign axis_count[0] = h_count;
  assign axis_count[1] = v_count;

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    assign axis_active[gi] = int'(axis_count[gi]) < ACTIVE_END[gi];
    assign axis_sync[gi]   = (int'(axis_count[gi]) >= SYNC_START[gi]) &&
                             (int'(axis_count[gi]) <  SYNC_END[gi]);
  end

  logic [COORD_W-1:0] x_reg;
  logic [COORD_W-1:0] y_reg;
  logic               de_reg;
  logic               hsync_reg;
  logic               vsync_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_reg     <= '0;
      y_reg     <= '0;
      de_reg    <= 1'b0;
      hsync_reg <= ~SYNC_POL;
      vsync_reg <= ~SYNC_POL;
    end else if (i_en) begin
      x_reg     <= h_count;
      y_reg     <= v_count;
      de_reg    <= &axis_active;
      hsync_reg <= axis_sync[0] ~^ SYNC_POL;
      vsync_reg <= axis_sync[1] ~^ SYNC_POL;
    end
  end

  assign o_x     = x_reg;
  assign o_y     = y_reg;
  assign o_de    = de_reg;
  assign o_hsync = hsync_reg;
  assign o_vsync = vsync_reg;

`ifdef VTG_ANIMATE_EN
  logic        animate_reg;
  logic [15:0] frame_reg;
  logic        frame_start;

  // First blanking line start; the pulse is cleared on disabled cycles so it never repeats.
  assign frame_start = (h_count == '0) && (v_count == COORD_W'(V_ACTIVE));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      animate_reg <= 1'b0;
      frame_reg   <= '0;
    end else begin
      animate_reg <= i_en && frame_start;
      if (i_en && frame_start) begin
        frame_reg <= frame_reg + 16'd1;
      end
    end
  end

  assign o_animate = animate_reg;
  assign o_frame   = frame_reg;
`else
  assign o_animate = 1'b0;
  assign o_frame   = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: two small-raster instances (active-high and active-low
// sync) checked every cycle against a closed-form model of the raster position.
module tb_video_timing_gen;

`ifdef VTG_ANIMATE_EN
  localparam int ANIM_ON = 1;
`else
  localparam int ANIM_ON = 0;
`endif

  // Instance A: 4/1/1/1 x 3/1/1/1 -> 7 x 6, active-high syncs.
  localparam int A_HA = 4, A_HF = 1, A_HS = 1, A_HB = 1;
  localparam int A_VA = 3, A_VF = 1, A_VS = 1, A_VB = 1;
  // Instance B: 5/2/1/2 x 4/1/2/1 -> 10 x 8, active-low syncs.
  localparam int B_HA = 5, B_HF = 2, B_HS = 1, B_HB = 2;
  localparam int B_VA = 4, B_VF = 1, B_VS = 2, B_VB = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  logic [11:0] a_x, a_y, b_x, b_y;
  logic        a_de, a_hs, a_vs, a_an, b_de, b_hs, b_vs, b_an;
  logic [15:0] a_fr, b_fr;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .SYNC_POL(1'b1)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .o_x(a_x), .o_y(a_y), .o_de(a_de), .o_hsync(a_hs), .o_vsync(a_vs),
    .o_animate(a_an), .o_frame(a_fr)
  );

  video_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .SYNC_POL(1'b0)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .o_x(b_x), .o_y(b_y), .o_de(b_de), .o_hsync(b_hs), .o_vsync(b_vs),
    .o_animate(b_an), .o_frame(b_fr)
  );

  typedef struct packed {
    int x; int y; int de; int hs; int vs; int an; int fr;
  } exp_t;

  // m = enabled clock edges since reset; the outputs after edge m show raster
  // position m-1 (row-major), since outputs trail the counters by one cycle.
  function automatic exp_t model(input int m, input bit last_en,
                                 input int ha, input int hf, input int hs, input int hb,
                                 input int va, input int vf, input int vs, input int vb,
                                 input bit pol);
    exp_t e;
    int ht, vt, p, hact, vact, start;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    if (m == 0) begin
      e = '{x: 0, y: 0, de: 0, hs: int'(!pol), vs: int'(!pol), an: 0, fr: 0};
    end else begin
      p     = (m - 1) % (ht * vt);
      e.x   = p % ht;
      e.y   = p / ht;
      e.de  = (e.x < ha && e.y < va) ? 1 : 0;
      hact  = (e.x >= ha + hf && e.x < ha + hf + hs) ? 1 : 0;
      vact  = (e.y >= va + vf && e.y < va + vf + vs) ? 1 : 0;
      e.hs  = pol ? hact : 1 - hact;
      e.vs  = pol ? vact : 1 - vact;
      e.an  = (last_en && e.x == 0 && e.y == va) ? ANIM_ON : 0;
      start = va * ht;
      e.fr  = (m - 1 >= start) ? ((((m - 1 - start) / (ht * vt)) + 1) % 65536) * ANIM_ON : 0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  int m_cnt   = 0;
  bit last_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= 0;
      last_en <= 1'b0;
    end else begin
      if (en) m_cnt <= m_cnt + 1;
      last_en <= en;
    end
  end

  // Every-cycle compare of both instances against the model.
  always @(negedge clk) begin
    exp_t ea, eb;
    ea = model(m_cnt, last_en, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, 1'b1);
    eb = model(m_cnt, last_en, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b0);
    chk("A.x", int'(a_x), ea.x);   chk("A.y", int'(a_y), ea.y);
    chk("A.de", int'(a_de), ea.de); chk("A.hsync", int'(a_hs), ea.hs);
    chk("A.vsync", int'(a_vs), ea.vs); chk("A.animate", int'(a_an), ea.an);
    chk("A.frame", int'(a_fr), ea.fr);
    chk("B.x", int'(b_x), eb.x);   chk("B.y", int'(b_y), eb.y);
    chk("B.de", int'(b_de), eb.de); chk("B.hsync", int'(b_hs), eb.hs);
    chk("B.vsync", int'(b_vs), eb.vs); chk("B.animate", int'(b_an), eb.an);
    chk("B.frame", int'(b_fr), eb.fr);
  end

  task automatic run_to(input int target);
    int budget;
    budget = 600;
    while (m_cnt != target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("run_to", m_cnt, target);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".A.x"}, int'(a_x), 0);       chk({tag, ".A.y"}, int'(a_y), 0);
    chk({tag, ".A.de"}, int'(a_de), 0);     chk({tag, ".A.hsync"}, int'(a_hs), 0);
    chk({tag, ".A.vsync"}, int'(a_vs), 0);  chk({tag, ".A.animate"}, int'(a_an), 0);
    chk({tag, ".A.frame"}, int'(a_fr), 0);
    chk({tag, ".B.x"}, int'(b_x), 0);       chk({tag, ".B.y"}, int'(b_y), 0);
    chk({tag, ".B.hsync"}, int'(b_hs), 1);  chk({tag, ".B.vsync"}, int'(b_vs), 1);
    chk({tag, ".B.frame"}, int'(b_fr), 0);
  endtask

  initial begin
    int hold_x, hold_y, hold_fr;
    int pause_at  [2] = '{106, 117};
    int pause_len [2] = '{10, 3};

    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    $display("phase reset: checking reset values");
    check_reset_values("reset");

    #1 rst_n = 1'b1; en = 1'b1;
    @(negedge clk);
    $display("phase first pixel: m=%0d x=%0d y=%0d de=%0d", m_cnt, a_x, a_y, a_de);
    chk("first.A.x", int'(a_x), 0);  chk("first.A.y", int'(a_y), 0);
    chk("first.A.de", int'(a_de), 1); chk("first.A.hsync", int'(a_hs), 0);
    chk("first.B.hsync", int'(b_hs), 1);

    run_to(6);
    $display("phase A hsync: x=%0d hsync=%0d", a_x, a_hs);
    chk("pin.A.hsync_x", int'(a_x), 5); chk("pin.A.hsync", int'(a_hs), 1);
    chk("pin.A.de_blank", int'(a_de), 0);

    run_to(8);
    $display("phase B hsync: x=%0d hsync=%0d", b_x, b_hs);
    chk("pin.B.hsync_x", int'(b_x), 7); chk("pin.B.hsync_low", int'(b_hs), 0);

    run_to(22);
    $display("phase A animate 1: x=%0d y=%0d animate=%0d frame=%0d", a_x, a_y, a_an, a_fr);
    chk("pin.A.anim_y", int'(a_y), 3); chk("pin.A.anim1", int'(a_an), ANIM_ON);
    chk("pin.A.frame1", int'(a_fr), ANIM_ON);

    run_to(29);
    $display("phase A vsync: y=%0d vsync=%0d", a_y, a_vs);
    chk("pin.A.vsync_y", int'(a_y), 4); chk("pin.A.vsync", int'(a_vs), 1);

    run_to(42);
    chk("pin.A.last_x", int'(a_x), 6); chk("pin.A.last_y", int'(a_y), 5);
    run_to(43);
    $display("phase A frame wrap: x=%0d y=%0d de=%0d", a_x, a_y, a_de);
    chk("pin.A.wrap_x", int'(a_x), 0); chk("pin.A.wrap_y", int'(a_y), 0);
    chk("pin.A.wrap_de", int'(a_de), 1);

    run_to(64);
    $display("phase A animate 2: animate=%0d frame=%0d", a_an, a_fr);
    chk("pin.A.frame2", int'(a_fr), 2 * ANIM_ON);

    for (int k = 0; k < 2; k++) begin
      run_to(pause_at[k]);
      hold_x  = int'(a_x);
      hold_y  = int'(a_y);
      hold_fr = int'(a_fr);
      #1 en = 1'b0;
      $display("phase pause %0d: holding at x=%0d y=%0d for %0d cycles", k, hold_x, hold_y, pause_len[k]);
      for (int c = 0; c < pause_len[k]; c++) begin
        @(negedge clk);
        chk("pause.A.x", int'(a_x), hold_x);
        chk("pause.A.y", int'(a_y), hold_y);
        chk("pause.A.frame", int'(a_fr), hold_fr);
        chk("pause.A.animate", int'(a_an), 0);
      end
      #1 en = 1'b1;
    end

    run_to(130);
    $display("phase async reset at x=%0d y=%0d", a_x, a_y);
    #3 rst_n = 1'b0;
    #1 check_reset_values("async");
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    run_to(125);
    $display("phase done: m=%0d B frame=%0d", m_cnt, b_fr);
    chk("pin.B.frame_after_reset", int'(b_fr), 2 * ANIM_ON);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing source for the HDMI test design. Free-running horizontal and vertical counters produce the pixel coordinates `o_x`/`o_y`, the sync and data-enable strobes for the HDMI transmitter, and the once-per-frame `o_animate` tick. The speed-bar and rectangle renderers consume these signals. Every output is registered and aligned to the same pixel.

## Interface
Parameters:
- `H_ACTIVE`, 1280: visible pixels per line
- `H_FP`, 110: horizontal front porch, in pixels
- `H_SYNC`, 40: hsync width, in pixels
- `H_BP`, 220: horizontal back porch, in pixels
- `V_ACTIVE`, 720: visible lines per frame
- `V_FP`, 5: vertical front porch, in lines
- `V_SYNC`, 5: vsync width, in lines
- `V_BP`, 20: vertical back porch, in lines
- `SYNC_POL`, 1: sync polarity; 1 = active-high, 0 = active-low

Ports:
- `i_clk`  in  1  pixel clock
- `i_rst_n`  in  1  asynchronous, active-low reset
- `i_en`  in  1  count enable; when low, the counters and all outputs hold
- `o_x`  out  12  horizontal position, 0..H_TOTAL-1
- `o_y`  out  12  vertical position, 0..V_TOTAL-1
- `o_de`  out  1  high while the pixel is in the active area
- `o_hsync`  out  1  horizontal sync, polarity per SYNC_POL
- `o_vsync`  out  1  vertical sync, polarity per SYNC_POL
- `o_animate`  out  1  one-cycle pulse per frame
- `o_frame`  out  16  frame count, wraps

## Operation
- Derived constants: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` (1650); `V_TOTAL` is formed the same way (750). Both totals must be at most 4096, which is checked at elaboration.
- The horizontal counter `h` counts 0..H_TOTAL-1 and wraps to 0.
- The vertical counter `v` increments only when `h` wraps, counts 0..V_TOTAL-1, and wraps to 0.
- Both counters advance only while `i_en` is high.
- Decoding:
  - `de = (h < H_ACTIVE) && (v < V_ACTIVE)`.
  - hsync is active for `H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC`.
  - vsync is active for `V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC`, over whole lines starting at `h = 0`.
- Output sync level is `active XNOR SYNC_POL`: with SYNC_POL = 0, an inactive sync line sits at 1.
- `o_x`/`o_y` carry `h`/`v` throughout, including blanking, so downstream range compares never see invalid values.
- `o_animate` pulses for exactly one enabled cycle when the counters reach `(h = 0, v = V_ACTIVE)`, the first blanking line. `o_frame` increments on that same cycle and wraps from 0xFFFF to 0.

## Timing
- Reset values:
  - `o_x`, `o_y`, `o_frame`: 0
  - `o_de`, `o_animate`: 0
  - `o_hsync`, `o_vsync`: the inactive level (`~SYNC_POL`)
  - internal `h`, `v`: 0
- Latency: every output is registered from the counter state, one cycle behind the counters, and all outputs are mutually aligned.
  - In the first enabled cycle after reset release, the outputs present `(0,0)` with `o_de = 1`.
- When `i_en` goes low, all outputs hold their values, except `o_animate`, which is forced to 0 so that no pulse is repeated.
- Wrap cases:
  - At the end of a frame (`h = H_TOTAL-1`, `v = V_TOTAL-1`), both counters return to 0 on the next enabled cycle.
  - At the end of a line, `v` increments on the same edge on which `h` wraps.
- A reset asserted mid-frame returns everything to the reset values immediately (asynchronous reset). Counting restarts at `(0,0)` on the first clock after deassertion.

## Configuration
- `VTG_ANIMATE_EN` defined: `o_animate` and the `o_frame` counter are implemented as described above.
- `VTG_ANIMATE_EN` undefined: `o_animate` is tied to 0, `o_frame` is tied to 0, and no frame counter flops are built. Sync, DE and coordinate outputs are unchanged.

## Structure
- Package `vtg_pkg` holds:
  - the timing constant sets `VTG_720P60` (the defaults above) and `VTG_1080P60` (1920/88/44/148, 1080/4/5/36);
  - the 12-bit coordinate width.
- Sub-module `vtg_wrap_counter`: a parameterized modulo-N counter with `i_inc` and `o_wrap`. It is instantiated twice, once for `h` and once for `v`, with the `h` counter's `o_wrap` gating the `v` counter's increment.

## Test plan
- Reset, then release with `i_en = 1` → `o_x = 0`, `o_y = 0`, `o_de = 1` on the first cycle; sync outputs inactive.
- Small parameters (4/1/1/1, 3/1/1/1, SYNC_POL = 1) → H_TOTAL = 7 and V_TOTAL = 6:
  - `o_hsync` is high only at `o_x = 5`;
  - `o_vsync` is high only while `o_y = 4`;
  - `o_de` is high only while `o_x < 4` and `o_y < 3`.
- Default 720p parameters:
  - exactly one `o_animate` pulse every 1,237,500 cycles, at `o_x = 0`, `o_y = 720`;
  - `o_frame` increments 0→1→2 over three frames.
- `i_en` toggled low for 10 cycles in mid-line → outputs frozen, `o_animate` = 0; counting resumes from the held position.
- Reset asserted at `o_x = 700`, `o_y = 400` → all outputs reach their reset values without waiting for a clock edge.
- Build without `VTG_ANIMATE_EN` → `o_animate` and `o_frame` stay 0 over two frames; sync and DE waveforms are identical to the build with the macro defined.
